// File: rtl/tisc_ctrl_seq.sv
// tisc_ctrl_seq: opcode decode, RAW-hazard scoreboard, run/drain/halt
// sequencing and saturating retire/stall counters for the TISC pipeline.
module tisc_ctrl_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [3:0]       rd,
    input  logic [3:0]       rs1,
    input  logic [3:0]       rs2,
    output logic [1:0]       alu_sel,
    output logic             reg_write_en,
    output logic             mem_write_en,
    output logic             mem_to_reg,
    output logic             mem_op,
    output logic             pc_en,
    output logic             bubble,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stalls
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] addr;
    } sb_entry_t;

    typedef struct packed {
        logic [1:0] alu_sel;
        logic       reg_write_en;
        logic       mem_write_en;
        logic       mem_to_reg;
        logic       mem_op;
    } strobes_t;

    state_e           state_q, state_d;
    sb_entry_t        sb_ex_q, sb_mem_q, sb_wb_q, sb_ex_d;
    logic             iv_ex_q, iv_mem_q, iv_wb_q, iv_ex_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;

    strobes_t dec;
    strobes_t strobes;
    logic     use_rs1, use_rs2, use_rd, is_halt, is_illegal;
    logic     hazard, stall_inc;

    // True when register r has a write pending in any of the three slots.
    function automatic logic pending(input logic [3:0] r, input sb_entry_t a,
                                     input sb_entry_t b, input sb_entry_t c);
        return (a.valid && a.addr == r) || (b.valid && b.addr == r) ||
               (c.valid && c.addr == r);
    endfunction

    // Decode the opcode at ID into strobes and the set of registers it reads.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode_e'(opcode))
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec.alu_sel      = opcode[1:0] - 2'd1;
                dec.reg_write_en = 1'b1;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_LOAD: begin
                dec.mem_op       = 1'b1;
                dec.mem_to_reg   = 1'b1;
                dec.reg_write_en = 1'b1;
            end
            OP_STORE: begin
                dec.mem_op       = 1'b1;
                dec.mem_write_en = 1'b1;
                use_rd           = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    // RAW check: the WB slot counts too since the register file has no bypass.
    always_comb begin
        hazard = (use_rs1 && pending(rs1, sb_ex_q, sb_mem_q, sb_wb_q)) ||
                 (use_rs2 && pending(rs2, sb_ex_q, sb_mem_q, sb_wb_q)) ||
                 (use_rd  && pending(rd,  sb_ex_q, sb_mem_q, sb_wb_q));
    end

    // FSM next state, issue/stall outputs and the new EX scoreboard entry.
    always_comb begin
        state_d   = state_q;
        sb_ex_d   = '0;
        iv_ex_d   = 1'b0;
        illegal_d = illegal_q;
        stall_inc = 1'b0;
        strobes   = '0;
        pc_en     = 1'b0;
        bubble    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (hazard) begin
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    strobes       = dec;
                    pc_en         = !is_halt;
                    sb_ex_d.valid = dec.reg_write_en;
                    sb_ex_d.addr  = rd;
                    iv_ex_d       = 1'b1;
                    if (is_illegal) illegal_d = 1'b1;
                    if (is_halt) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // WB shifts out on this edge, so only EX and MEM must be empty.
                if (!sb_ex_q.valid && !sb_mem_q.valid) state_d = ST_HALTED;
            end
            ST_HALTED: halted = 1'b1;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Saturating counters: retire when an issued slot leaves WB.
    always_comb begin
        retired_d = retired_q;
        stalls_d  = stalls_q;
        if (iv_wb_q && retired_q != '1) retired_d = retired_q + CNT_W'(1);
        if (stall_inc && stalls_q != '1) stalls_d = stalls_q + CNT_W'(1);
    end

    // State registers with synchronous reset; the scoreboard shifts every cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= ST_IDLE;
            sb_ex_q   <= '0;
            sb_mem_q  <= '0;
            sb_wb_q   <= '0;
            iv_ex_q   <= 1'b0;
            iv_mem_q  <= 1'b0;
            iv_wb_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            stalls_q  <= '0;
        end else begin
            state_q   <= state_d;
            sb_ex_q   <= sb_ex_d;
            sb_mem_q  <= sb_ex_q;
            sb_wb_q   <= sb_mem_q;
            iv_ex_q   <= iv_ex_d;
            iv_mem_q  <= iv_ex_q;
            iv_wb_q   <= iv_mem_q;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            stalls_q  <= stalls_d;
        end
    end

    assign alu_sel      = strobes.alu_sel;
    assign reg_write_en = strobes.reg_write_en;
    assign mem_write_en = strobes.mem_write_en;
    assign mem_to_reg   = strobes.mem_to_reg;
    assign mem_op       = strobes.mem_op;
    assign illegal      = illegal_q;
    assign retired      = retired_q;
    assign stalls       = stalls_q;

endmodule

// File: tb/tb_tisc_ctrl_seq.sv
// Self-checking bench for tisc_ctrl_seq: directed scenarios followed by a
// randomized instruction stream, all compared against a cycle-history model.
module tb_tisc_ctrl_seq;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [3:0]    opcode, rd, rs1, rs2;
    logic [1:0]    alu_sel;
    logic          reg_write_en, mem_write_en, mem_to_reg, mem_op;
    logic          pc_en, bubble, halted, illegal;
    logic [CW-1:0] retired, stalls;

    tisc_ctrl_seq #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .alu_sel      (alu_sel),
        .reg_write_en (reg_write_en),
        .mem_write_en (mem_write_en),
        .mem_to_reg   (mem_to_reg),
        .mem_op       (mem_op),
        .pc_en        (pc_en),
        .bubble       (bubble),
        .halted       (halted),
        .illegal      (illegal),
        .retired      (retired),
        .stalls       (stalls)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: history of issues indexed by cycle number.
    int         cyc = 0;
    int         m_mode = M_IDLE;
    int         m_halt_at = 0;
    int         m_ret = 0;
    int         m_stl = 0;
    bit         m_ill = 1'b0;
    bit         w_at[int];
    logic [3:0] w_reg[int];
    bit         i_at[int];

    // One clock cycle: drive, compare mid-cycle, advance model, wait for edge.
    task automatic step(input bit rst_i, input bit start_i, input logic [3:0] op,
                        input logic [3:0] r_d, input logic [3:0] r_s1,
                        input logic [3:0] r_s2, output bit issued);
        logic [5:0] e_str;
        bit         e_pc, e_bub, e_halt, hazard, stall;
        logic [3:0] srcs[$];
        rst    = rst_i;
        start  = start_i;
        opcode = op;
        rd     = r_d;
        rs1    = r_s1;
        rs2    = r_s2;
        issued = 1'b0;
        stall  = 1'b0;
        hazard = 1'b0;
        e_str  = '0;
        e_pc   = 1'b0;
        e_bub  = 1'b0;
        e_halt = 1'b0;
        if (m_mode == M_DRAIN && cyc >= m_halt_at) m_mode = M_HALTED;
        #4;
        if (m_mode == M_RUN) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: begin srcs.push_back(r_s1); srcs.push_back(r_s2); end
                4'h9: srcs.push_back(r_d);
                default: ;
            endcase
            foreach (srcs[i])
                for (int k = 1; k <= 3; k++)
                    if (w_at.exists(cyc - k) && w_reg[cyc - k] == srcs[i]) hazard = 1'b1;
            if (hazard) begin
                e_bub = 1'b1;
                stall = 1'b1;
            end else begin
                issued = 1'b1;
                e_pc   = (op != 4'hF);
                // Strobe order: {alu_sel[1:0], reg_write_en, mem_write_en, mem_to_reg, mem_op}
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: e_str = {2'(int'(op) - 1), 4'b1000};
                    4'h8: e_str = 6'b00_1011;
                    4'h9: e_str = 6'b00_0101;
                    default: e_str = '0;
                endcase
                i_at[cyc] = 1'b1;
                if (e_str[3]) begin
                    w_at[cyc]  = 1'b1;
                    w_reg[cyc] = r_d;
                end
            end
        end else if (m_mode == M_HALTED) begin
            e_halt = 1'b1;
        end
        if (!rst_i) begin
            check("pc_en", pc_en, e_pc);
            check("bubble", bubble, e_bub);
            check("strobes", {alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op}, e_str);
        end
        check("halted", halted, e_halt);
        check("illegal", illegal, m_ill);
        check("retired", retired, m_ret);
        check("stalls", stalls, m_stl);
        if (rst_i) begin
            m_mode = M_IDLE;
            m_ret  = 0;
            m_stl  = 0;
            m_ill  = 1'b0;
            w_at.delete();
            w_reg.delete();
            i_at.delete();
            issued = 1'b0;
        end else begin
            if (i_at.exists(cyc - 3) && m_ret < SAT) m_ret++;
            if (stall && m_stl < SAT) m_stl++;
            if (m_mode == M_IDLE && start_i) m_mode = M_RUN;
            if (issued && !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hF}))
                m_ill = 1'b1;
            if (issued && op == 4'hF) begin
                m_mode    = M_DRAIN;
                m_halt_at = cyc + 2 + (w_at.exists(cyc - 1) ? 1 : 0);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Hold one instruction at ID until it issues (bounded).
    task automatic issue(input logic [3:0] op, input logic [3:0] r_d,
                         input logic [3:0] r_s1, input logic [3:0] r_s2, input bit rnd_start);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 8 && !ok; n++)
            step(1'b0, rnd_start ? 1'($urandom_range(0, 1)) : 1'b0, op, r_d, r_s1, r_s2, ok);
    endtask

    function automatic logic [3:0] rand_op();
        int r;
        r = $urandom_range(0, 19);
        if (r < 10)       return 4'(1 + r % 4);
        else if (r < 13)  return 4'h8;
        else if (r < 16)  return 4'h9;
        else if (r == 17) return 4'hF;
        else if (r == 18) return 4'($urandom_range(10, 14));
        else              return 4'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset, then ADD at ID without start: stays idle
        repeat (2) step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, ok);
        repeat (10) step(1'b0, 1'b0, 4'h1, 4'h1, 4'h2, 4'h3, ok);

        // Independent stream
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, ok);
        issue(4'h1, 4'd1, 4'd2, 4'd3, 1'b0);
        issue(4'h2, 4'd4, 4'd5, 4'd6, 1'b0);
        issue(4'h4, 4'd7, 4'd8, 4'd9, 1'b0);
        repeat (4) issue(4'h0, 4'd0, 4'd0, 4'd0, 1'b0);

        // RAW stall
        issue(4'h1, 4'd1, 4'd2, 4'd3, 1'b0);
        issue(4'h3, 4'd5, 4'd1, 4'd4, 1'b0);

        // LOAD then dependent STORE
        issue(4'h8, 4'd2, 4'd0, 4'd0, 1'b0);
        issue(4'h9, 4'd2, 4'd0, 4'd0, 1'b0);

        // Dependent chain drives both counters into saturation
        repeat (7) issue(4'h1, 4'd1, 4'd1, 4'd1, 1'b0);
        repeat (6) issue(4'h0, 4'd0, 4'd0, 4'd0, 1'b0);

        // Halt drain behind a pending LOAD, start ignored afterwards
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, ok);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, ok);
        issue(4'h8, 4'd1, 4'd0, 4'd0, 1'b0);
        issue(4'hF, 4'd1, 4'd0, 4'd0, 1'b0);
        repeat (8) step(1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, ok);

        // Illegal opcode, then reset in the middle of a stall
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, ok);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, ok);
        issue(4'h6, 4'd3, 4'd3, 4'd3, 1'b0);
        repeat (3) issue(4'h0, 4'd0, 4'd0, 4'd0, 1'b0);
        issue(4'h1, 4'd1, 4'd2, 4'd3, 1'b0);
        step(1'b0, 1'b0, 4'h3, 4'd5, 4'd1, 4'd4, ok);
        step(1'b1, 1'b0, 4'h3, 4'd5, 4'd1, 4'd4, ok);
        repeat (3) step(1'b0, 1'b0, 4'h3, 4'd5, 4'd1, 4'd4, ok);

        // start coinciding with rst: stays idle
        step(1'b1, 1'b1, 4'h1, 4'd1, 4'd2, 4'd3, ok);
        repeat (3) step(1'b0, 1'b0, 4'h1, 4'd1, 4'd2, 4'd3, ok);

        // Randomized stream
        for (int it = 0; it < 700; it++) begin
            case (m_mode)
                M_IDLE:  step(1'b0, 1'($urandom_range(0, 1)), rand_op(), 4'($urandom_range(0, 3)),
                              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), ok);
                M_RUN: begin
                    if ($urandom_range(0, 59) == 0)
                        step(1'b1, 1'($urandom_range(0, 1)), 4'h0, 4'h0, 4'h0, 4'h0, ok);
                    else
                        issue(rand_op(), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                              4'($urandom_range(0, 3)), 1'b1);
                end
                M_DRAIN: step(1'b0, 1'($urandom_range(0, 1)), rand_op(), 4'($urandom_range(0, 3)),
                              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), ok);
                default: begin
                    step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, ok);
                    step(1'b1, 1'($urandom_range(0, 1)), 4'h0, 4'h0, 4'h0, 4'h0, ok);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
